// File: rtl/inst_fetch_queue_pkg.sv
// inst_fetch_queue_pkg: shared widths, reset PC and queue entry layout for the fetch queue.
// FETCH_ADEL_EN adds an address-error flag to each queue entry.
package inst_fetch_queue_pkg;
    localparam int W_DATA = 32;
    localparam logic [W_DATA-1:0] RESET_PC_DEFAULT = 32'hBFC00000;
`ifdef FETCH_ADEL_EN
    typedef struct packed {
        logic              adel;
        logic [W_DATA-1:0] word;
        logic [W_DATA-1:0] pc;
    } entry_t;
`else
    typedef struct packed {
        logic [W_DATA-1:0] word;
        logic [W_DATA-1:0] pc;
    } entry_t;
`endif
    function automatic logic [W_DATA-1:0] next_pc(input logic [W_DATA-1:0] pc);
        return pc + 32'd4;
    endfunction
endpackage

// File: rtl/inst_fetch_queue_if.sv
// inst_fetch_queue_if: redirect, instruction-memory and ID-stage signals of the fetch queue.
interface inst_fetch_queue_if;
    import inst_fetch_queue_pkg::*;
    logic              flush;
    logic [W_DATA-1:0] flush_pc;
    logic              req_valid;
    logic [W_DATA-1:0] req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic [W_DATA-1:0] resp_data;
    logic              inst_valid;
    logic [W_DATA-1:0] inst;
    logic [W_DATA-1:0] inst_pc;
    logic              inst_ready;
    logic              inst_adel;
    modport master (
        input  flush, flush_pc, req_ready, resp_valid, resp_data, inst_ready,
        output req_valid, req_addr, inst_valid, inst, inst_pc, inst_adel
    );
    modport slave (
        output flush, flush_pc, req_ready, resp_valid, resp_data, inst_ready,
        input  req_valid, req_addr, inst_valid, inst, inst_pc, inst_adel
    );
endinterface

// File: rtl/inst_fetch_queue_fifo.sv
// sync_fifo: register-based FIFO with combinational head read, clear and occupancy count.
module sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;
    always_comb begin
        do_pop  = pop && count != '0;
        do_push = push && (count != FULL || do_pop);
        dout    = mem[rd_ptr];
    end
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: sequential fetch address generator with credit-limited issue and in-order instruction queue to ID.
// FETCH_ADEL_EN turns a misaligned PC into a single address-error entry and halts fetch until the next flush.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [W_DATA-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input logic clk,
    input logic rst,
    inst_fetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [W_DATA-1:0] pc, pc_head;
    logic [AW:0]       inflight, drop, count;
    logic [AW+1:0]     credit;
    logic              can_req, fire, resp_ok, push, pop, valid;
    entry_t            din, head;
    always_comb begin
        credit  = {1'b0, count} + {1'b0, inflight} - {1'b0, drop};
        resp_ok = bus.resp_valid && inflight != '0;
        can_req = !rst && !bus.flush && credit < {1'b0, FULL} && inflight < FULL;
        valid   = count != '0;
        pop     = valid && bus.inst_ready;
        fire    = bus.req_valid && bus.req_ready;
    end
`ifdef FETCH_ADEL_EN
    logic halted, adel_push;
    always_comb begin
        bus.req_valid = can_req && pc[1:0] == 2'b00 && !halted;
        bus.req_addr  = pc;
        // The error entry waits until every live request has returned so it stays in program order.
        adel_push     = !rst && !bus.flush && pc[1:0] != 2'b00 && !halted && inflight == drop && count != FULL;
        push          = (resp_ok && drop == '0 && !bus.flush) || adel_push;
        din           = adel_push ? '{adel: 1'b1, word: '0, pc: pc} : '{adel: 1'b0, word: bus.resp_data, pc: pc_head};
        bus.inst_adel = valid && head.adel;
    end
    always_ff @(posedge clk)
        halted <= (rst || bus.flush) ? 1'b0 : halted || adel_push;
`else
    always_comb begin
        bus.req_valid = can_req;
        bus.req_addr  = pc & ~32'h3;
        push          = resp_ok && drop == '0 && !bus.flush;
        din           = '{word: bus.resp_data, pc: pc_head};
        bus.inst_adel = 1'b0;
    end
`endif
    always_comb begin
        bus.inst_valid = valid;
        bus.inst       = valid ? head.word : '0;
        bus.inst_pc    = valid ? head.pc : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pc   <= RESET_PC;
            drop <= '0;
        end else begin
            pc   <= bus.flush ? bus.flush_pc : fire ? next_pc(pc) : pc;
            drop <= bus.flush ? inflight - (AW+1)'(resp_ok) : drop - (AW+1)'(resp_ok && drop != '0);
        end
    end
    // The request-PC FIFO occupancy is exactly the number of requests in flight.
    sync_fifo #(.W(W_DATA), .DEPTH(DEPTH)) u_pc_fifo (
        .clk(clk), .rst(rst), .clear(1'b0), .push(fire), .pop(resp_ok),
        .din(bus.req_addr), .dout(pc_head), .count(inflight)
    );
    sync_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_data_fifo (
        .clk(clk), .rst(rst), .clear(bus.flush), .push(push), .pop(pop),
        .din(din), .dout(head), .count(count)
    );
endmodule
